// File: rtl/seq_mask_detect.sv
// Serial pattern detector with per-bit don't-care mask, runtime-loadable pattern/mask,
// overlapping or non-overlapping match modes and a saturating match counter.
module seq_mask_detect #(
  parameter int             LEN      = 9,
  parameter logic [LEN-1:0] DEF_PAT  = 9'b011000110,
  parameter logic [LEN-1:0] DEF_MASK = 9'b111000111,
  parameter int             CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             a_vld,
  input  logic             overlap,
  input  logic             cfg_we,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic [LEN-1:0]   cfg_mask,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam int               FW      = $clog2(LEN + 1);
  localparam logic [FW-1:0]    FULL    = FW'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LEN-1:0]   sr_q, sr_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic [LEN-1:0]   mask_q, mask_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN-1:0] nsr;
  logic [FW-1:0]  nfill;
  logic           hit;

  // Post-shift view of the window; a config load overrides the hit entirely.
  assign nsr   = {sr_q[LEN-2:0], a};
  assign nfill = (fill_q == FULL) ? FULL : fill_q + FW'(1);
  assign hit   = a_vld && !cfg_we && (nfill == FULL) && (((nsr ^ pat_q) & mask_q) == '0);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    sr_d    = sr_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    if (cfg_we) begin
      pat_d  = cfg_pattern;
      mask_d = cfg_mask;
      sr_d   = '0;
      fill_d = '0;
    end else if (a_vld) begin
      sr_d    = nsr;
      fill_d  = (hit && !overlap) ? '0 : nfill;
      match_d = hit;
    end

    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      pat_q   <= DEF_PAT;
      mask_q  <= DEF_MASK;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign busy      = (fill_q < FULL);

endmodule

// File: tb/tb_seq_mask_detect.sv
// Self-checking bench for seq_mask_detect: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model.
module tb_seq_mask_detect;

  localparam int LEN   = 9;
  localparam int CNT_W = 8;
  localparam logic [LEN-1:0] DEF_PAT  = 9'b011000110;
  localparam logic [LEN-1:0] DEF_MASK = 9'b111000111;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a, a_vld, overlap, cfg_we, cnt_clr;
  logic [LEN-1:0]   cfg_pattern, cfg_mask;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;

  seq_mask_detect #(
    .LEN(LEN), .DEF_PAT(DEF_PAT), .DEF_MASK(DEF_MASK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .a_vld(a_vld), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: window of the last LEN accepted bits (index 0 oldest),
  // plus a count of bits accepted since the last restart.
  bit             win[$];
  int             m_fill;
  logic [LEN-1:0] m_pat, m_mask;
  bit             m_match;
  int             m_cnt;

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < LEN; i++) win.push_back(1'b0);
    m_fill  = 0;
    m_pat   = DEF_PAT;
    m_mask  = DEF_MASK;
    m_match = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit ok;
    int nf;
    ok = 1'b0;
    if (cfg_we) begin
      m_pat  = cfg_pattern;
      m_mask = cfg_mask;
      m_fill = 0;
      for (int i = 0; i < LEN; i++) win[i] = 1'b0;
    end else if (a_vld) begin
      win.push_back(a);
      void'(win.pop_front());
      nf = (m_fill + 1 > LEN) ? LEN : m_fill + 1;
      ok = (nf == LEN);
      // window[i] lines up with pattern bit LEN-1-i (first-received bit is the MSB)
      for (int i = 0; i < LEN; i++)
        if (m_mask[LEN-1-i] && (win[i] != m_pat[LEN-1-i])) ok = 1'b0;
      m_fill = (ok && !overlap) ? 0 : nf;
    end
    m_match = ok;
    if (cnt_clr) m_cnt = ok ? 1 : 0;
    else if (ok && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (match === 1'b1) pulses++;
    check("match", match, m_match);
    check("match_cnt", match_cnt, m_cnt);
    check("busy", busy, (m_fill < LEN));
  endtask

  task automatic drive(input logic b, input logic v, input logic we, input logic clr);
    a = b; a_vld = v; cfg_we = we; cnt_clr = clr;
    tick();
    cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load_cfg(input logic [LEN-1:0] p, input logic [LEN-1:0] m);
    cfg_pattern = p; cfg_mask = m;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Sends LEN bits MSB first, with an optional run of invalid cycles before bit gap_at.
  task automatic send_bits(input logic [LEN-1:0] s, input int gap_at, input int gap_len);
    for (int i = LEN - 1; i >= 0; i--) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) drive($urandom_range(0, 1), 1'b0, 1'b0, 1'b0);
      drive(s[i], 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [LEN-1:0] stream;
    int p0;
    stream = 9'b011101110;
    rst_n = 1'b0; a = 0; a_vld = 0; overlap = 1; cfg_we = 0; cnt_clr = 0;
    cfg_pattern = '0; cfg_mask = '0;
    model_reset();
    #12;
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_busy", busy, 1);
    @(negedge clk); rst_n = 1'b1;

    // default pattern, contiguous
    send_bits(stream, -1, 0);
    check("dflt_match", match, 1);
    check("dflt_cnt", match_cnt, 1);
    check("dflt_busy", busy, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("dflt_pulse_end", match, 0);

    // same stream with a 3-cycle valid gap mid-pattern
    load_cfg(DEF_PAT, DEF_MASK);
    p0 = pulses;
    send_bits(stream, 4, 3);
    check("gap_match", match, 1);
    check("gap_pulses", pulses - p0, 1);

    // alternating stream against 101010101, overlap on then off
    for (int ov = 1; ov >= 0; ov--) begin
      overlap = ov[0];
      load_cfg(9'b101010101, '1);
      p0 = pulses;
      for (int i = 0; i < 13; i++) drive(~i[0], 1'b1, 1'b0, 1'b0);
      check(ov ? "ovl1_hits" : "ovl0_hits", pulses - p0, ov ? 3 : 1);
    end

    // config load mid-sequence drops the sampled bit and restarts collection
    overlap = 1'b1;
    load_cfg(DEF_PAT, DEF_MASK);
    for (int i = LEN - 1; i > LEN - 6; i--) drive(stream[i], 1'b1, 1'b0, 1'b0);
    cfg_pattern = DEF_PAT; cfg_mask = DEF_MASK;
    p0 = pulses;
    drive(stream[LEN-6], 1'b1, 1'b1, 1'b0);
    check("cfg_busy", busy, 1);
    send_bits(stream, -1, 0);
    check("cfg_match", match, 1);
    check("cfg_pulses", pulses - p0, 1);

    // all-don't-care mask, saturating counter, then clear on a hit cycle
    load_cfg($urandom, '0);
    for (int i = 0; i < 300; i++) drive($urandom_range(0, 1), 1'b1, 1'b0, 1'b0);
    check("sat_cnt", match_cnt, CNT_MAX);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_on_hit", match_cnt, 1);

    // asynchronous reset while partially through a sequence
    load_cfg(DEF_PAT, DEF_MASK);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    overlap = 1'b0;
    for (int k = 0; k < 3; k++) send_bits(stream, -1, 0);
    for (int i = LEN - 1; i > LEN - 6; i--) drive(stream[i], 1'b1, 1'b0, 1'b0);
    check("pre_rst_cnt", match_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_match", match, 0);
    check("arst_cnt", match_cnt, 0);
    check("arst_busy", busy, 1);
    @(negedge clk); rst_n = 1'b1;
    send_bits(stream, -1, 0);
    check("post_rst_match", match, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      overlap     = ($urandom_range(0, 3) != 0);
      cfg_pattern = $urandom;
      cfg_mask    = $urandom & $urandom & $urandom;
      drive($urandom_range(0, 1), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_mask_detect.md
Name: seq_mask_detect

Overview:
- Parametrised serial sequence detector with per-bit don't-care masking and a runtime-programmable pattern and mask.
- Supports overlapping or non-overlapping match modes, an input-valid qualifier, and a saturating match counter.
- Used as a generic pattern detector on 1-bit serial streams; default configuration detects 011xxx110.

Parameters:
- LEN, 9, pattern length in bits (2..32).
- DEF_PAT, 9'b011000110, pattern loaded at reset; bit LEN-1 is the first-received bit.
- DEF_MASK, 9'b111000111, mask loaded at reset; 1 = compare, 0 = don't care.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  1  serial data bit.
- a_vld  in  1  a is sampled only when 1.
- overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cfg_we  in  1  load cfg_pattern and cfg_mask this cycle.
- cfg_pattern  in  LEN  new pattern.
- cfg_mask  in  LEN  new mask.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- busy  out  1  1 while fewer than LEN valid bits have been collected since the last restart.

Behaviour:
- Reset values:
  - shift register = 0; fill = 0.
  - pattern = DEF_PAT; mask = DEF_MASK.
  - match = 0; match_cnt = 0; busy = 1.
- Shift register sr[LEN-1:0]:
  - On a clock edge with a_vld=1, sr <= {sr[LEN-2:0], a}.
  - sr[LEN-1] holds the oldest bit, sr[0] the newest.
  - When a_vld=0, sr and fill hold.
- Fill counter:
  - Counts accepted bits and saturates at LEN.
  - busy = (fill < LEN), decoded from registered fill.
- Match condition, evaluated on an edge with a_vld=1:
  - Let nsr be the post-shift value and nfill = min(fill+1, LEN).
  - hit = (nfill == LEN) && (((nsr ^ pattern) & mask) == 0).
- Match output:
  - match <= hit on that edge; otherwise match <= 0.
  - Latency: match is high for exactly the one cycle following the edge that samples the final pattern bit.
- Overlap behaviour:
  - overlap=1: fill stays at LEN after a hit, so consecutive hits are possible, including every cycle.
  - overlap=0: a hit sets fill <= 0, so the next hit needs LEN fresh valid bits. sr still shifts normally.
- overlap is sampled every cycle. Changing it mid-stream affects only subsequent hits.
- Config load (cfg_we=1):
  - pattern <= cfg_pattern; mask <= cfg_mask; fill <= 0; sr <= 0; match <= 0.
  - The a bit on that cycle is discarded, even if a_vld=1.
  - cfg_we has priority over detection.
- Counter:
  - On a hit, match_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 takes priority: match_cnt <= (hit ? 1 : 0).
  - cnt_clr does not affect sr, fill or match.
- Mask corner cases:
  - mask = all zeros: every accepted bit hits once fill reaches LEN (subject to the overlap rule).
  - mask = all ones: exact match.
- Reset asserted mid-stream: all state returns immediately to reset values, pattern and mask revert to DEF_PAT and DEF_MASK, and any partial sequence is lost.
- No combinational path from inputs to any output.

Test Plan:
- Defaults, a_vld=1, stream 0,1,1,1,0,1,1,1,0 -> match=1 for exactly one cycle after the 9th bit; match_cnt=1; busy falls after the 9th bit.
- Same stream with a_vld=0 inserted for 3 cycles mid-pattern -> identical single match pulse, delayed by 3 cycles; no spurious match.
- overlap=1, cfg_pattern=4'b1010, cfg_mask=4'b1111, LEN=4, stream 1,0,1,0,1,0 -> matches after bits 4 and 6. Repeat with overlap=0 -> match after bit 4 only.
- cfg_we pulsed with a_vld=1 partway through a valid default sequence -> the sampled bit is dropped, busy=1, no match until LEN new bits form the new pattern.
- Hold a pattern that matches every cycle (mask=0, overlap=1) for 300 cycles with CNT_W=8 -> match_cnt saturates at 255. cnt_clr on a hit cycle -> match_cnt=1.
- Assert rst_n=0 while fill=5 and match_cnt=3 -> outputs return to reset values asynchronously. After release, the default pattern is detected from scratch.
